// File: rtl/peak_gen.sv
// Framed AXI-Stream test-pattern source: baseline gap then an NTX_TRIG-sample peak burst with marker strobe.
// Optional frame counter enabled by defining PEAK_GEN_FRAME_CNT_EN.
module peak_gen #(
   parameter int unsigned DATA_WIDTH   = 16,
   parameter int unsigned NTX_TRIG     = 16,
   parameter int unsigned PERIOD_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    enable,
   input  logic [PERIOD_WIDTH-1:0] period,
   input  logic [DATA_WIDTH-1:0]   baseline,
   input  logic [DATA_WIDTH-1:0]   peak_amp,
   output logic [DATA_WIDTH-1:0]   out_tdata,
   output logic                    out_tvalid,
   input  logic                    out_tready,
   output logic                    out_tlast,
   output logic                    peak_stb_out,
   output logic                    busy,
   output logic [31:0]             frame_count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_GAP  = 2'd1;
   localparam logic [1:0] S_PEAK = 2'd2;

   localparam logic [PERIOD_WIDTH-1:0] NTX = PERIOD_WIDTH'(NTX_TRIG);

   logic [1:0]              r_state, w_state;
   logic [PERIOD_WIDTH-1:0] r_cnt, w_cnt;
   logic [PERIOD_WIDTH-1:0] r_per, w_per;
   logic [DATA_WIDTH-1:0]   r_tdata, w_tdata;
   logic                    r_tvalid, w_tvalid;
   logic                    r_tlast, w_tlast;
   logic                    r_stb, w_stb;
   logic                    r_busy, w_busy;

   logic                    w_beat;
   logic [PERIOD_WIDTH-1:0] w_per_clamp;
   logic [PERIOD_WIDTH-1:0] w_next_idx;
   logic [PERIOD_WIDTH-1:0] w_gap_len;

   assign w_beat      = r_tvalid & out_tready;
   assign w_per_clamp = (period <= NTX) ? (NTX + PERIOD_WIDTH'(1)) : period;
   assign w_next_idx  = r_cnt + PERIOD_WIDTH'(1);
   assign w_gap_len   = r_per - NTX;

   // Registers hold the sample currently presented; a new one loads from IDLE or on a beat.
   always_comb begin
      w_state  = r_state;
      w_cnt    = r_cnt;
      w_per    = r_per;
      w_tdata  = r_tdata;
      w_tvalid = r_tvalid;
      w_tlast  = r_tlast;
      w_stb    = r_stb;
      if (clear) begin
         w_state  = S_IDLE;
         w_cnt    = '0;
         w_per    = '0;
         w_tdata  = '0;
         w_tvalid = 1'b0;
         w_tlast  = 1'b0;
         w_stb    = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (enable) begin
                  w_state  = S_GAP;
                  w_cnt    = '0;
                  w_per    = w_per_clamp;
                  w_tdata  = baseline;
                  w_tvalid = 1'b1;
                  w_tlast  = 1'b0;
                  w_stb    = 1'b0;
               end
            end
            S_GAP, S_PEAK: begin
               if (w_beat) begin
                  if (r_tlast) begin
                     if (enable) begin
                        w_state  = S_GAP;
                        w_cnt    = '0;
                        w_per    = w_per_clamp;
                        w_tdata  = baseline;
                        w_tvalid = 1'b1;
                        w_tlast  = 1'b0;
                        w_stb    = 1'b0;
                     end else begin
                        w_state  = S_IDLE;
                        w_tvalid = 1'b0;
                        w_tlast  = 1'b0;
                        w_stb    = 1'b0;
                     end
                  end else begin
                     w_cnt = w_next_idx;
                     if (w_next_idx >= w_gap_len) begin
                        w_state = S_PEAK;
                        w_tdata = peak_amp;
                        w_stb   = 1'b1;
                        w_tlast = (w_next_idx == (r_per - PERIOD_WIDTH'(1)));
                     end else begin
                        w_state = S_GAP;
                        w_tdata = baseline;
                        w_stb   = 1'b0;
                        w_tlast = 1'b0;
                     end
                  end
               end
            end
            default: begin
               w_state  = S_IDLE;
               w_tvalid = 1'b0;
               w_tlast  = 1'b0;
               w_stb    = 1'b0;
            end
         endcase
      end
      w_busy = (w_state != S_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_per    <= '0;
         r_tdata  <= '0;
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
         r_stb    <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_cnt    <= w_cnt;
         r_per    <= w_per;
         r_tdata  <= w_tdata;
         r_tvalid <= w_tvalid;
         r_tlast  <= w_tlast;
         r_stb    <= w_stb;
         r_busy   <= w_busy;
      end
   end

   assign out_tdata    = r_tdata;
   assign out_tvalid   = r_tvalid;
   assign out_tlast    = r_tlast;
   assign peak_stb_out = r_stb;
   assign busy         = r_busy;

`ifdef PEAK_GEN_FRAME_CNT_EN
   logic [31:0] r_frame_cnt;
   logic        w_frame_done;

   assign w_frame_done = r_tvalid & out_tready & r_tlast;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)             r_frame_cnt <= '0;
      else if (clear)        r_frame_cnt <= '0;
      else if (w_frame_done) r_frame_cnt <= r_frame_cnt + 32'd1;
   end

   assign frame_count = r_frame_cnt;
`else
   assign frame_count = '0;
`endif

endmodule
